// File: rtl/cdc_bus_tx_sched.sv
// Source-domain scheduler for the multi-bit bus synchronizer. It arbitrates two
// requesters round-robin and launches one word at a time with fixed enable hold and gap.
module cdc_bus_tx_sched #(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 6,
  parameter int GAP_CYCLES  = 6,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req0_valid,
  input  logic [BUS_WIDTH-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [BUS_WIDTH-1:0] req1_data,
  output logic                 req1_ready,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LOAD  = CNT_WIDTH'(GAP_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [BUS_WIDTH-1:0] bus_nxt;
  logic                 en_nxt;
  logic                 gid_nxt;
  logic                 last_grant, last_grant_nxt;
  logic                 sel1;
  logic                 accept;

  always_comb begin
    // req1 wins when it is alone, or when both ask and req0 had the last grant
    sel1       = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = (state == IDLE) & req0_valid & ~sel1;
    req1_ready = (state == IDLE) & sel1;
    accept     = req0_ready | req1_ready;

    state_nxt      = state;
    cnt_nxt        = cnt;
    bus_nxt        = unsync_bus;
    en_nxt         = bus_enable;
    gid_nxt        = grant_id;
    last_grant_nxt = last_grant;

    case (state)
      IDLE: begin
        if (accept) begin
          bus_nxt        = sel1 ? req1_data : req0_data;
          gid_nxt        = sel1;
          last_grant_nxt = sel1;
          en_nxt         = 1'b1;
          cnt_nxt        = HOLD_LOAD;
          state_nxt      = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          en_nxt    = 1'b0;
          cnt_nxt   = GAP_LOAD;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt - CNT_WIDTH'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_WIDTH'(1);
        end
      end
      default: begin
        en_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      cnt        <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      unsync_bus <= bus_nxt;
      bus_enable <= en_nxt;
      grant_id   <= gid_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cdc_bus_tx_sched.sv
// Randomized scoreboard bench for cdc_bus_tx_sched: a cycle-level model of the
// word schedule plus a monitor that matches every launched word against a queue.
module tb_cdc_bus_tx_sched;

  localparam int BW = 8;
  localparam int H  = 6;
  localparam int G  = 6;

  typedef struct packed {
    logic          g;
    logic [BW-1:0] d;
  } word_t;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [BW-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic [BW-1:0] unsync_bus;
  logic          bus_enable, grant_id, busy;

  logic          rst1 = 1'b0;
  logic          a_valid = 1'b0;
  logic [BW-1:0] a_data = '0;
  logic          a_ready, b_ready;
  logic [BW-1:0] a_bus;
  logic          a_en, a_gid, a_busy;

  int checks = 0;
  int errors = 0;

  word_t exp_q[$];

  // model state
  int            rem = 0;
  logic          m_last = 1'b1;
  logic          m_gid = 1'b0;
  logic [BW-1:0] m_data = '0;
  logic          pend0 = 1'b0, pend1 = 1'b0;
  logic [BW-1:0] dat0 = '0, dat1 = '0;

  always #5 CLK = ~CLK;

  cdc_bus_tx_sched #(.BUS_WIDTH(BW), .HOLD_CYCLES(H), .GAP_CYCLES(G), .CNT_WIDTH(4)) u_dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .unsync_bus(unsync_bus), .bus_enable(bus_enable), .grant_id(grant_id), .busy(busy)
  );

  cdc_bus_tx_sched #(.BUS_WIDTH(BW), .HOLD_CYCLES(1), .GAP_CYCLES(1), .CNT_WIDTH(4)) u_dut_min (
    .CLK(CLK), .RST(rst1),
    .req0_valid(a_valid), .req0_data(a_data), .req0_ready(a_ready),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_ready(b_ready),
    .unsync_bus(a_bus), .bus_enable(a_en), .grant_id(a_gid), .busy(a_busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One source cycle: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic idle, w1;
    word_t w;
    req0_valid = pend0;
    req0_data  = pend0 ? dat0 : 8'($urandom);
    req1_valid = pend1;
    req1_data  = pend1 ? dat1 : 8'($urandom);
    @(negedge CLK);
    idle = (rem == 0);
    w1   = pend1 && (!pend0 || (m_last == 1'b0));
    chk("req0_ready", 32'(req0_ready), 32'(idle && pend0 && !w1));
    chk("req1_ready", 32'(req1_ready), 32'(idle && w1));
    chk("busy", 32'(busy), 32'(rem > 0));
    chk("bus_enable", 32'(bus_enable), 32'(rem > G));
    chk("unsync_bus", 32'(unsync_bus), 32'(m_data));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    @(posedge CLK);
    if (idle && (pend0 || pend1)) begin
      w.g    = w1;
      w.d    = w1 ? dat1 : dat0;
      exp_q.push_back(w);
      m_last = w1;
      m_gid  = w1;
      m_data = w.d;
      rem    = H + G;
      if (w1) pend1 = 1'b0;
      else    pend0 = 1'b0;
    end else if (rem > 0) begin
      rem--;
    end
    #1;
  endtask

  // Monitor: every rising enable edge must carry the next expected word.
  initial begin
    logic prev_en;
    word_t w;
    prev_en = 1'b0;
    forever begin
      @(negedge CLK);
      if (bus_enable && !prev_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(unsync_bus), 32'hFFFF_FFFF);
        end else begin
          w = exp_q.pop_front();
          chk("sb_data", 32'(unsync_bus), 32'(w.d));
          chk("sb_grant", 32'(grant_id), 32'(w.g));
        end
      end
      prev_en = bus_enable;
    end
  end

  // Minimum-timing instance: one hold cycle, one gap cycle, one idle cycle.
  initial begin
    logic [BW-1:0] last_d;
    int ph;
    last_d = '0;
    #12 chk("min_reset_en", 32'(a_en), 32'h0);
    @(negedge CLK) rst1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      #1;
      a_valid = 1'b1;
      a_data  = 8'($urandom);
      @(negedge CLK);
      ph = i % 3;
      chk("min_ready", 32'(a_ready), 32'(ph == 0));
      chk("min_en", 32'(a_en), 32'(ph == 1));
      chk("min_busy", 32'(a_busy), 32'(ph != 0));
      if (ph == 0) last_d = a_data;
      if (ph == 1) chk("min_bus", 32'(a_bus), 32'(last_d));
    end
    a_valid = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    // reset state
    #7;
    chk("rst_en", 32'(bus_enable), 32'h0);
    chk("rst_bus", 32'(unsync_bus), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_r0", 32'(req0_ready), 32'h0);
    chk("rst_r1", 32'(req1_ready), 32'h0);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) step();

    // single word from req0, then a second one right behind it
    pend0 = 1'b1; dat0 = 8'hA5;
    step();
    pend0 = 1'b1; dat0 = 8'h5A;
    for (int i = 0; i < 14; i++) step();

    // both requesters continuously
    for (int i = 0; i < 56; i++) begin
      if (!pend0) begin pend0 = 1'b1; dat0 = 8'h11; end
      if (!pend1) begin pend1 = 1'b1; dat1 = 8'h22; end
      step();
    end
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 14; i++) step();

    // req1 arrives during req0's hold phase
    pend0 = 1'b1; dat0 = 8'($urandom);
    for (int i = 0; i < 3; i++) step();
    pend1 = 1'b1; dat1 = 8'($urandom);
    for (int i = 0; i < 28; i++) step();

    // reset in the middle of a hold phase
    pend0 = 1'b1; dat0 = 8'hC3;
    guard = 0;
    while (!(rem == H + G - 3) && guard < 40) begin
      step();
      guard++;
    end
    chk("reach_mid_hold", 32'(rem), 32'(H + G - 3));
    pend0 = 1'b0; pend1 = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    RST = 1'b0;
    #1;
    chk("async_rst_en", 32'(bus_enable), 32'h0);
    chk("async_rst_bus", 32'(unsync_bus), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    rem = 0; m_last = 1'b1; m_gid = 1'b0; m_data = '0;
    exp_q.delete();
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK);
    #1;
    pend0 = 1'b1; dat0 = 8'h33;
    pend1 = 1'b1; dat1 = 8'h44;
    for (int i = 0; i < 30; i++) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && $urandom_range(3) == 0) begin pend0 = 1'b1; dat0 = 8'($urandom); end
      if (!pend1 && $urandom_range(3) == 0) begin pend1 = 1'b1; dat1 = 8'($urandom); end
      step();
    end
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 16; i++) step();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
